// File: rtl/mem_ctrl_pkg.sv
// Shared encodings for the byte-serial memory controller and the CPU stages.
// Holds FSM state encodings, MEM-stage rw codes and bus-owner codes.
// Also provides the access-length decode used at request acceptance.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_READ  = 2'b01,
    ST_WRITE = 2'b10,
    ST_DONE  = 2'b11
  } state_t;

  // MEM-stage request codes; 2'b11 is treated like RW_NONE
  localparam logic [1:0] RW_NONE  = 2'b00;
  localparam logic [1:0] RW_READ  = 2'b01;
  localparam logic [1:0] RW_WRITE = 2'b10;

  // Bus owner codes reported on IF_or_MEM
  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_MEM  = 2'b01;
  localparam logic [1:0] OWN_IF   = 2'b10;

  // Only 1 and 2 are honoured as short accesses; anything else is a word
  function automatic logic [2:0] decode_len(input logic [2:0] len);
    case (len)
      3'd1:    return 3'd1;
      3'd2:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Arbitrates IF and MEM requests onto a byte-wide synchronous RAM, one byte per cycle.
// Latency: read n+2 cycles, write n+1 cycles from the acceptance edge to the DONE pulse.
// No backpressure: a pending request simply waits in IDLE; MEM wins over IF.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int RAM_ADDR_WIDTH = 17
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      if_req,
  input  logic [31:0]               if_addr,
  input  logic [1:0]                rw_in,
  input  logic [31:0]               addr_mem_in,
  input  logic [2:0]                data_length_in,
  input  logic [31:0]               data_mem_in,
  output logic [1:0]                IF_or_MEM,
  output logic                      busy_out,
  output logic                      done_out,
  output logic [31:0]               data_out,
  output logic [RAM_ADDR_WIDTH-1:0] ram_addr,
  output logic [7:0]                ram_dout,
  input  logic [7:0]                ram_din,
  output logic                      ram_wr
);

  state_t      state_q, state_d;
  logic [1:0]  owner_q, owner_d;
  logic [31:0] base_q, base_d;
  logic [2:0]  len_q, len_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;

  // Byte lanes: the write lane follows the counter, the read lane trails it by one
  // because RAM data arrives a cycle after its address.
  logic [4:0]                wr_lsb;
  logic [4:0]                rd_lsb;
  logic [RAM_ADDR_WIDTH-1:0] cur_addr;

  assign wr_lsb   = {cnt_q[1:0], 3'b000};
  assign rd_lsb   = {cnt_q[1:0] - 2'd1, 3'b000};
  // Full 32-bit wrap first, then truncate to the RAM width
  assign cur_addr = RAM_ADDR_WIDTH'(base_q + {29'd0, cnt_q});

  // State and transaction context registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      owner_q <= OWN_NONE;
      base_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      base_q  <= base_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Next state: accept in IDLE, step one byte per cycle, single-cycle DONE
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    base_d  = base_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (rw_in == RW_READ || rw_in == RW_WRITE) begin
          owner_d = OWN_MEM;
          base_d  = addr_mem_in;
          len_d   = decode_len(data_length_in);
          wdata_d = data_mem_in;
          cnt_d   = 3'd0;
          rdata_d = 32'd0;
          state_d = (rw_in == RW_READ) ? ST_READ : ST_WRITE;
        end else if (if_req) begin
          owner_d = OWN_IF;
          base_d  = if_addr;
          len_d   = 3'd4;
          cnt_d   = 3'd0;
          rdata_d = 32'd0;
          state_d = ST_READ;
        end
      end
      ST_READ: begin
        // cnt_q == len_q is the extra cycle that only collects the last byte
        if (cnt_q != 3'd0) rdata_d[rd_lsb +: 8] = ram_din;
        if (cnt_q == len_q) state_d = ST_DONE;
        else                cnt_d   = cnt_q + 3'd1;
      end
      ST_WRITE: begin
        if (cnt_q == len_q - 3'd1) state_d = ST_DONE;
        else                       cnt_d   = cnt_q + 3'd1;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        owner_d = OWN_NONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from state so reset clears them without waiting for a clock
  always_comb begin
    IF_or_MEM = OWN_NONE;
    busy_out  = 1'b0;
    done_out  = 1'b0;
    ram_addr  = '0;
    ram_dout  = 8'd0;
    ram_wr    = 1'b0;
    case (state_q)
      ST_READ: begin
        busy_out  = 1'b1;
        IF_or_MEM = owner_q;
        if (cnt_q != len_q) ram_addr = cur_addr;
      end
      ST_WRITE: begin
        busy_out  = 1'b1;
        IF_or_MEM = owner_q;
        ram_addr  = cur_addr;
        ram_dout  = wdata_q[wr_lsb +: 8];
        ram_wr    = 1'b1;
      end
      ST_DONE: begin
        done_out  = 1'b1;
        IF_or_MEM = owner_q;
      end
      default: ;
    endcase
  end

  assign data_out = rdata_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: directed scenarios followed by random traffic.
// A byte-array memory model predicts read data, write contents and address streams.
// A synchronous RAM model with one-cycle read latency sits on the RAM port.
module tb_mem_ctrl;

  localparam int AW  = 17;
  localparam int MSZ = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          if_req = 1'b0;
  logic [31:0]   if_addr = 32'd0;
  logic [1:0]    rw_in = 2'b00;
  logic [31:0]   addr_mem_in = 32'd0;
  logic [2:0]    data_length_in = 3'd0;
  logic [31:0]   data_mem_in = 32'd0;
  logic [1:0]    IF_or_MEM;
  logic          busy_out;
  logic          done_out;
  logic [31:0]   data_out;
  logic [AW-1:0] ram_addr;
  logic [7:0]    ram_dout;
  logic [7:0]    ram_din;
  logic          ram_wr;

  int checks = 0;
  int errors = 0;

  logic [7:0] ram     [MSZ];
  logic [7:0] exp_mem [MSZ];

  mem_ctrl #(.RAM_ADDR_WIDTH(AW)) dut (
    .clk            (clk),
    .rst            (rst),
    .if_req         (if_req),
    .if_addr        (if_addr),
    .rw_in          (rw_in),
    .addr_mem_in    (addr_mem_in),
    .data_length_in (data_length_in),
    .data_mem_in    (data_mem_in),
    .IF_or_MEM      (IF_or_MEM),
    .busy_out       (busy_out),
    .done_out       (done_out),
    .data_out       (data_out),
    .ram_addr       (ram_addr),
    .ram_dout       (ram_dout),
    .ram_din        (ram_din),
    .ram_wr         (ram_wr)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] init_byte(input int unsigned a);
    return 8'((a * 32'd37) ^ (a >> 5) ^ 32'h5A);
  endfunction

  function automatic int eff_len(input logic [2:0] l);
    return (l == 3'd1) ? 1 : (l == 3'd2) ? 2 : 4;
  endfunction

  // Synchronous byte RAM: read-first, data valid the cycle after the address
  initial begin
    ram_din = 8'd0;
    for (int i = 0; i < MSZ; i++) ram[i] = init_byte(i);
    forever begin
      @(posedge clk);
      ram_din <= ram[ram_addr];
      if (ram_wr) ram[ram_addr] = ram_dout;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Request inputs must already be presented; the next rising edge accepts it.
  task automatic run_txn(input bit is_if, input bit is_wr, input logic [31:0] base,
                         input int n, input logic [31:0] wdata, input bit keep_if);
    logic [31:0]   exp_rd;
    logic [AW-1:0] a;
    logic [AW-1:0] qa[$];
    bit            qw[$];
    logic [7:0]    qd[$];
    int            done_c;
    int            nwr;
    logic [1:0]    own;
    own    = is_if ? 2'b10 : 2'b01;
    exp_rd = 32'd0;
    for (int k = 0; k < n; k++) begin
      a = AW'(base + 32'(k));
      if (is_wr) exp_mem[a] = wdata[8*k +: 8];
      else       exp_rd = exp_rd | (32'(exp_mem[a]) << (8*k));
    end
    @(posedge clk);
    #1;
    rw_in = 2'b00;
    if (!keep_if) begin
      if_req  = 1'b0;
      if_addr = $urandom;
    end
    done_c = 0;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      if (done_out) begin
        done_c = c;
        break;
      end
      if (busy_out) begin
        qa.push_back(ram_addr);
        qw.push_back(ram_wr);
        qd.push_back(ram_dout);
      end
      // Input noise while busy must not disturb the latched transaction
      rw_in          = 2'($urandom_range(0, 3));
      addr_mem_in    = $urandom;
      data_length_in = 3'($urandom);
      data_mem_in    = $urandom;
    end
    chk("latency", 32'(done_c), 32'(is_wr ? n + 1 : n + 2));
    chk("owner_in_done", 32'(IF_or_MEM), 32'(own));
    chk("busy_in_done", 32'(busy_out), 32'd0);
    chk("wr_in_done", 32'(ram_wr), 32'd0);
    if (!is_wr) chk("read_data", data_out, exp_rd);
    chk("busy_cycles", 32'(qa.size()), 32'(is_wr ? n : n + 1));
    nwr = 0;
    foreach (qw[i]) if (qw[i]) nwr++;
    chk("write_strobes", 32'(nwr), 32'(is_wr ? n : 0));
    for (int k = 0; k < n && k < qa.size(); k++) begin
      chk("ram_addr_seq", 32'(qa[k]), 32'(AW'(base + 32'(k))));
      if (is_wr) chk("ram_dout_seq", 32'(qd[k]), 32'(wdata[8*k +: 8]));
    end
    if (is_wr) begin
      for (int k = 0; k < n; k++) begin
        a = AW'(base + 32'(k));
        chk("ram_content", 32'(ram[a]), 32'(exp_mem[a]));
      end
    end
    // A request visible during DONE must be ignored
    rw_in = 2'($urandom_range(1, 2));
    @(negedge clk);
    chk("idle_owner", 32'(IF_or_MEM), 32'd0);
    chk("idle_busy", 32'(busy_out), 32'd0);
    chk("idle_done", 32'(done_out), 32'd0);
    rw_in = 2'b00;
  endtask

  // Present a request at a negedge in IDLE; 'both' also raises a competing IF fetch.
  task automatic issue(input bit is_if, input bit is_wr, input logic [31:0] a,
                       input logic [2:0] len, input logic [31:0] d, input bit both);
    logic [31:0] fa;
    if (is_if) begin
      if_req  = 1'b1;
      if_addr = a;
      run_txn(1'b1, 1'b0, a, 4, 32'd0, 1'b0);
    end else begin
      rw_in          = is_wr ? 2'b10 : 2'b01;
      addr_mem_in    = a;
      data_length_in = len;
      data_mem_in    = d;
      fa             = $urandom;
      if (both) begin
        if_req  = 1'b1;
        if_addr = fa;
      end
      run_txn(1'b0, is_wr, a, eff_len(len), d, both);
      if (both) run_txn(1'b1, 1'b0, fa, 4, 32'd0, 1'b0);
    end
  endtask

  initial begin
    logic [31:0] ra;
    for (int i = 0; i < MSZ; i++) exp_mem[i] = init_byte(i);

    // Reset applied without any clock edge
    #1 rst = 1'b1;
    #2;
    chk("rst_owner", 32'(IF_or_MEM), 32'd0);
    chk("rst_busy", 32'(busy_out), 32'd0);
    chk("rst_done", 32'(done_out), 32'd0);
    chk("rst_data", data_out, 32'd0);
    chk("rst_addr", 32'(ram_addr), 32'd0);
    chk("rst_dout", 32'(ram_dout), 32'd0);
    chk("rst_wr", 32'(ram_wr), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Word read of a known pattern
    issue(1'b0, 1'b1, 32'h100, 3'd4, 32'h44332211, 1'b0);
    issue(1'b0, 1'b0, 32'h100, 3'd4, 32'd0, 1'b0);
    // Halfword write, upper bytes ignored
    issue(1'b0, 1'b1, 32'h200, 3'd2, 32'hAABBCCDD, 1'b0);
    // Simultaneous MEM and IF: MEM first, IF right after
    issue(1'b0, 1'b0, 32'h200, 3'd2, 32'd0, 1'b1);
    // Byte at top of RAM space, read back zero-extended
    issue(1'b0, 1'b1, 32'h0001FFFF, 3'd1, 32'h12345680, 1'b0);
    issue(1'b0, 1'b0, 32'h0001FFFF, 3'd1, 32'd0, 1'b0);
    // Word read across the 32-bit wrap
    issue(1'b0, 1'b0, 32'hFFFFFFFF, 3'd4, 32'd0, 1'b0);
    // Illegal length behaves as a word
    issue(1'b0, 1'b1, 32'h400, 3'd3, 32'hCAFEF00D, 1'b0);
    issue(1'b1, 1'b0, 32'h400, 3'd4, 32'd0, 1'b0);

    // Reset between edges during the third byte of a word write
    rw_in          = 2'b10;
    addr_mem_in    = 32'h300;
    data_length_in = 3'd4;
    data_mem_in    = 32'hDEADBEEF;
    @(posedge clk);
    #1 rw_in = 2'b00;
    repeat (3) @(negedge clk);
    chk("abort_pre_wr", 32'(ram_wr), 32'd1);
    chk("abort_pre_addr", 32'(ram_addr), 32'h302);
    #1 rst = 1'b1;
    #1;
    chk("abort_wr", 32'(ram_wr), 32'd0);
    chk("abort_busy", 32'(busy_out), 32'd0);
    chk("abort_owner", 32'(IF_or_MEM), 32'd0);
    chk("abort_addr", 32'(ram_addr), 32'd0);
    chk("abort_data", data_out, 32'd0);
    exp_mem[17'h300] = 8'hEF;
    exp_mem[17'h301] = 8'hBE;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("post_abort_done", 32'(done_out), 32'd0);
      chk("post_abort_busy", 32'(busy_out), 32'd0);
    end
    for (int k = 0; k < 4; k++)
      chk("abort_content", 32'(ram[17'h300 + 17'(k)]), 32'(exp_mem[17'h300 + 17'(k)]));
    issue(1'b0, 1'b0, 32'h300, 3'd4, 32'd0, 1'b0);

    // Random traffic, biased towards the address wrap points
    for (int t = 0; t < 40; t++) begin
      case ($urandom_range(0, 2))
        0:       ra = $urandom;
        1:       ra = 32'hFFFFFFFF - 32'($urandom_range(0, 3));
        default: ra = 32'h0001FFFC + 32'($urandom_range(0, 3));
      endcase
      case ($urandom_range(0, 3))
        0:       issue(1'b1, 1'b0, ra, 3'd4, 32'd0, 1'b0);
        1:       issue(1'b0, 1'b1, ra, 3'($urandom), $urandom, 1'($urandom));
        default: issue(1'b0, 1'b0, ra, 3'($urandom), 32'd0, 1'($urandom));
      endcase
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
